dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_align.sv | 49 ++++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   SIZE_B / SIZE_H / SIZE_W : legal access sizes in bytes
//   MAX_WAIT_CYCLES          : upper bound for the WAIT_CYCLES parameter
//   state_t                  : responder FSM state encoding
//   req_error()              : classifies a request as illegal
package dmem_pkg;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    localparam int unsigned MAX_WAIT_CYCLES = 15;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Conflicting request, unsupported size, misalignment or out-of-range word.
    function automatic logic req_error(
        input logic        ld,
        input logic        st,
        input logic [2:0]  sz,
        input logic [31:0] a,
        input int unsigned depth
    );
        logic bad;
        bad = ld & st;
        case (sz)
            SIZE_B: ;
            SIZE_H: if (a[0]) bad = 1'b1;
            SIZE_W: if (a[1:0] != 2'b00) bad = 1'b1;
            default: bad = 1'b1;
        endcase
        if ({2'b00, a[31:2]} >= depth) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the control unit
// (master) and the data-memory responder (slave).
//   load_mem, store_mem : request strobes
//   size, sign          : access size in bytes, load sign-extension select
//   addr, wdata         : byte address, right-aligned store data
//   rdata               : extended load data
//   done, fault         : one-cycle completion / error completion pulses
//   busy                : stall request back to the control unit
interface dmem_responder_if;

    logic        load_mem;
    logic        store_mem;
    logic [2:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        fault;
    logic        busy;

    modport master (
        output load_mem, store_mem, size, sign, addr, wdata,
        input  rdata, done, fault, busy
    );

    modport slave (
        input  load_mem, store_mem, size, sign, addr, wdata,
        output rdata, done, fault, busy
    );

endinterface

// File: rtl/dmem_align.sv
// dmem_align: combinational byte-lane steering for the data memory.
//   size, sign : access size in bytes, sign-extend select for loads
//   offset     : addr[1:0] of the access
//   wdata      : right-aligned store data
//   rword      : full 32-bit word read from storage
//   byte_en    : little-endian byte-lane write enables
//   wlane      : store data shifted into its byte lanes
//   rext       : addressed lane shifted down and zero/sign extended
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic        sign,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wlane,
    output logic [31:0] rext
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt = {offset, 3'b000};

    always_comb begin
        wlane   = wdata << shamt;
        rshift  = rword >> shamt;
        byte_en = '0;
        rext    = '0;
        case (size)
            SIZE_B: begin
                byte_en = 4'b0001 << offset;
                rext    = {{24{sign & rshift[7]}}, rshift[7:0]};
            end
            SIZE_H: begin
                byte_en = 4'b0011 << offset;
                rext    = {{16{sign & rshift[15]}}, rshift[15:0]};
            end
            SIZE_W: begin
                byte_en = 4'b1111;
                rext    = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory answering load/store requests
// from the control unit with a fixed latency of WAIT_CYCLES+1 edges.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset (storage is not cleared)
//   bus     : request/response bundle, slave side
// Parameters: DEPTH_WORDS (32-bit words of storage), WAIT_CYCLES (0..15).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    dmem_responder_if.slave  bus
);

    localparam int unsigned     IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        lat_load;
    logic        lat_store;
    logic        lat_sign;
    logic [2:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] rdata_q;
    logic        done_q;
    logic        fault_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             req;
    logic             cur_load;
    logic             cur_store;
    logic             cur_sign;
    logic [2:0]       cur_size;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic             enter_resp;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      rword;
    logic [3:0]       byte_en;
    logic [31:0]      wlane;
    logic [31:0]      rext;

    assign req = bus.load_mem | bus.store_mem;

    // With WAIT_CYCLES=0 the access completes on the accepting edge, so in
    // IDLE the live inputs stand in for the not-yet-latched copy.
    assign cur_load  = (state == IDLE) ? bus.load_mem  : lat_load;
    assign cur_store = (state == IDLE) ? bus.store_mem : lat_store;
    assign cur_sign  = (state == IDLE) ? bus.sign      : lat_sign;
    assign cur_size  = (state == IDLE) ? bus.size      : lat_size;
    assign cur_addr  = (state == IDLE) ? bus.addr      : lat_addr;
    assign cur_wdata = (state == IDLE) ? bus.wdata     : lat_wdata;

    assign cur_err = req_error(cur_load, cur_store, cur_size, cur_addr, DEPTH_WORDS);

    assign enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0))
                     || ((state == WAIT) && (cnt == '0));

    assign mem_we  = reset_n && enter_resp && cur_store && !cur_err;
    assign mem_idx = cur_addr[IDX_W+1:2];
    assign rword   = mem[mem_idx];

    dmem_align u_align (
        .size    (cur_size),
        .sign    (cur_sign),
        .offset  (cur_addr[1:0]),
        .wdata   (cur_wdata),
        .rword   (rword),
        .byte_en (byte_en),
        .wlane   (wlane),
        .rext    (rext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            lat_load  <= 1'b0;
            lat_store <= 1'b0;
            lat_sign  <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_load  <= bus.load_mem;
                        lat_store <= bus.store_mem;
                        lat_sign  <= bus.sign;
                        lat_size  <= bus.size;
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                done_q  <= !cur_err;
                fault_q <= cur_err;
                rdata_q <= (cur_err || cur_store) ? '0 : rext;
            end
        end
    end

    // Storage has no reset; writes are gated by reset_n so an aborted
    // access never reaches the array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[mem_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign bus.busy  = req && (state != RESP);
    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder with three instances
// (WAIT_CYCLES = 1, 0 and 3) sharing one clock.
module tb_dmem_responder;

    logic clk;
    logic rst_n;
    logic rst3_n;

    int total = 0;
    int bad   = 0;

    dmem_responder_if bus1 ();
    dmem_responder_if bus0 ();
    dmem_responder_if bus3 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset_n(rst_n), .bus(bus1)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(rst_n), .bus(bus0)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset_n(rst3_n), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the instance idle; ends at a negedge, idle again.
    task automatic access1(input string tag, input logic ld, input logic st,
                           input logic [2:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic exp_fault, input logic [31:0] exp_rdata);
        bus1.load_mem = ld; bus1.store_mem = st; bus1.size = sz;
        bus1.sign = sg; bus1.addr = a; bus1.wdata = wd;
        #1 check({tag, ".busy_acc"}, {31'd0, bus1.busy}, 32'd1);
        @(negedge clk);
        check({tag, ".busy_wait"}, {31'd0, bus1.busy}, 32'd1);
        check({tag, ".early"}, {30'd0, bus1.done, bus1.fault}, 32'd0);
        @(negedge clk);
        check({tag, ".done"},  {31'd0, bus1.done},  {31'd0, !exp_fault});
        check({tag, ".fault"}, {31'd0, bus1.fault}, {31'd0, exp_fault});
        check({tag, ".busy_resp"}, {31'd0, bus1.busy}, 32'd0);
        check({tag, ".rdata"}, bus1.rdata, exp_rdata);
        bus1.load_mem = 1'b0; bus1.store_mem = 1'b0;
        @(negedge clk);
        check({tag, ".pulse_end"}, {30'd0, bus1.done, bus1.fault}, 32'd0);
        check({tag, ".rdata_hold"}, bus1.rdata, exp_rdata);
    endtask

    task automatic access3(input string tag, input logic ld, input logic st,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rdata);
        bus3.load_mem = ld; bus3.store_mem = st; bus3.size = 3'd4;
        bus3.sign = 1'b0; bus3.addr = a; bus3.wdata = wd;
        repeat (3) begin
            @(negedge clk);
            check({tag, ".wait"}, {29'd0, bus3.busy, bus3.done, bus3.fault}, 32'd4);
        end
        @(negedge clk);
        check({tag, ".done"}, {30'd0, bus3.done, bus3.fault}, 32'd2);
        check({tag, ".rdata"}, bus3.rdata, exp_rdata);
        bus3.load_mem = 1'b0; bus3.store_mem = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        bus1.load_mem = 0; bus1.store_mem = 0; bus1.size = 0; bus1.sign = 0; bus1.addr = 0; bus1.wdata = 0;
        bus0.load_mem = 0; bus0.store_mem = 0; bus0.size = 0; bus0.sign = 0; bus0.addr = 0; bus0.wdata = 0;
        bus3.load_mem = 0; bus3.store_mem = 0; bus3.size = 0; bus3.sign = 0; bus3.addr = 0; bus3.wdata = 0;
        rst_n = 1'b0;
        rst3_n = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.w1", {bus1.rdata[30:0], bus1.done, bus1.fault, bus1.busy} , 34'd0 >> 2);
        check("rst.w1_rdata", bus1.rdata, 32'd0);
        check("rst.w3_outs", {29'd0, bus3.done, bus3.fault, bus3.busy}, 32'd0);
        rst_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);

        // Word store then load, 2-edge latency
        access1("st_w10", 1'b0, 1'b1, 3'd4, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        access1("ld_w10", 1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Byte store with sign/zero extension, word view of the merge
        access1("st_b13", 1'b0, 1'b1, 3'd1, 1'b0, 32'h13, 32'h00000080, 1'b0, 32'h0);
        access1("ld_b13s", 1'b1, 1'b0, 3'd1, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
        access1("ld_b13z", 1'b1, 1'b0, 3'd1, 1'b0, 32'h13, 32'h0, 1'b0, 32'h00000080);
        access1("ld_w10b", 1'b1, 1'b0, 3'd4, 1'b1, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF);
        access1("ld_h12s", 1'b1, 1'b0, 3'd2, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF80AD);
        access1("ld_h10z", 1'b1, 1'b0, 3'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000BEEF);
        access1("st_h10", 1'b0, 1'b1, 3'd2, 1'b0, 32'h10, 32'h12345678, 1'b0, 32'h0);
        access1("ld_w10c", 1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD5678);

        // Error requests: fault pulse, rdata cleared, no write
        access1("f_ld_h11", 1'b1, 1'b0, 3'd2, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0);
        access1("ld_w10d", 1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD5678);
        access1("f_st_w12", 1'b0, 1'b1, 3'd4, 1'b0, 32'h12, 32'hFFFFFFFF, 1'b1, 32'h0);
        access1("f_sz3", 1'b1, 1'b0, 3'd3, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0);
        access1("f_both", 1'b1, 1'b1, 3'd4, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0);
        access1("ld_w10e", 1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD5678);

        // Address range boundary
        access1("st_last", 1'b0, 1'b1, 3'd4, 1'b0, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
        access1("ld_last", 1'b1, 1'b0, 3'd4, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D);
        access1("f_oob", 1'b1, 1'b0, 3'd4, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);

        // WAIT_CYCLES=0: store then continuously held loads
        bus0.store_mem = 1'b1; bus0.size = 3'd4; bus0.addr = 32'h4; bus0.wdata = 32'h0000ABCD;
        #1 check("w0.st_busy", {31'd0, bus0.busy}, 32'd1);
        @(negedge clk);
        check("w0.st_done", {29'd0, bus0.done, bus0.fault, bus0.busy}, 32'd4);
        bus0.store_mem = 1'b0; bus0.load_mem = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("w0.done_seq", {31'd0, bus0.done}, {31'd0, (i % 2) == 1});
            check("w0.busy_seq", {31'd0, bus0.busy}, {31'd0, (i % 2) == 0});
            if (bus0.done) begin
                pulses++;
                check("w0.rdata", bus0.rdata, 32'h0000ABCD);
            end
        end
        check("w0.pulses", pulses, 3);
        bus0.load_mem = 1'b0;
        @(negedge clk);
        check("w0.quiet", {30'd0, bus0.done, bus0.busy}, 32'd0);

        // WAIT_CYCLES=3: reset in the second WAIT cycle aborts the store
        access3("w3.st", 1'b0, 1'b1, 32'h20, 32'h11223344, 32'h0);
        access3("w3.ld", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11223344);
        bus3.store_mem = 1'b1; bus3.size = 3'd4; bus3.addr = 32'h20; bus3.wdata = 32'hAABBCCDD;
        @(negedge clk);
        @(posedge clk);
        #2 rst3_n = 1'b0;
        #1 check("w3.rst_outs", {30'd0, bus3.done, bus3.fault}, 32'd0);
        check("w3.rst_rdata", bus3.rdata, 32'd0);
        @(negedge clk);
        bus3.store_mem = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus3.done) pulses++;
        end
        check("w3.no_done", pulses, 0);
        rst3_n = 1'b1;
        @(negedge clk);
        access3("w3.ld_after", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
